// File: rtl/x_mux_sweep_pkg.sv
// Shared types and constants for the mux-trigger sweep sequencer.
package x_mux_sweep_pkg;

  // Control word layout towards the mux-trigger datapath.
  localparam int unsigned FIRE_BIT = 8;
  localparam int unsigned SEL_LSB  = 0;

  // Result sum: up to 128 repetitions x 32 set bits = 4096, needs 13 bits.
  localparam int unsigned SUM_W = 13;

  // Repetition counter covers 2^0 .. 2^7 repetitions.
  localparam int unsigned REP_W = 7;

  // Settle counter; SETTLE is limited to 1..15.
  localparam int unsigned WAIT_W = 4;

  typedef logic [2:0] sweep_state_t;

  localparam sweep_state_t StIdle   = 3'd0;
  localparam sweep_state_t StArm    = 3'd1;
  localparam sweep_state_t StFire   = 3'd2;
  localparam sweep_state_t StWait   = 3'd3;
  localparam sweep_state_t StSample = 3'd4;
  localparam sweep_state_t StEmit   = 3'd5;

  // Index of the final repetition for a given log2 repetition count (2^n - 1).
  function automatic logic [REP_W-1:0] rep_last(input logic [2:0] reps_log2);
    logic [REP_W-1:0] ones;
    ones = '1;
    return ~(ones << reps_log2);
  endfunction

endpackage

// File: rtl/x_popcount.sv
// Combinational population count of a DATA_W-bit word.
module x_popcount #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  count_o
);

  // Ripple sum of the individual bits; the parent registers the result.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      count_o = count_o + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/x_mux_sweep_ctrl.sv
// Mux-trigger sweep sequencer: steps the mux select from first to last, fires the
// trigger 2^reps_log2 times per select, accumulates the sample popcounts and hands
// one result per select out over a valid/ready handshake.
module x_mux_sweep_ctrl
  import x_mux_sweep_pkg::*;
#(
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETTLE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [SEL_W-1:0]  i_sel_first,
  input  logic [SEL_W-1:0]  i_sel_last,
  input  logic [2:0]        i_reps_log2,
  output logic [DATA_W-1:0] o_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [SEL_W-1:0]  o_res_sel,
  output logic [SUM_W-1:0]  o_res_sum,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned       PCNT_W     = $clog2(DATA_W + 1);
  localparam logic [WAIT_W-1:0] SettleLast = WAIT_W'(SETTLE - 1);

  // Control word with only the select field and the fire bit populated.
  function automatic logic [DATA_W-1:0] ctrl_word(input logic [SEL_W-1:0] sel,
                                                  input logic             fire);
    logic [DATA_W-1:0] w;
    w                    = '0;
    w[SEL_LSB +: SEL_W]  = sel;
    w[FIRE_BIT]          = fire;
    return w;
  endfunction

  // Sequencer state and latched configuration.
  sweep_state_t      state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [2:0]        log2_q, log2_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  // Registered outputs.
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  res_sel_q, res_sel_d;
  logic [SUM_W-1:0]  res_sum_q, res_sum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [PCNT_W-1:0] data_pcnt;

  x_popcount #(
    .DATA_W (DATA_W),
    .CNT_W  (PCNT_W)
  ) u_popcount (
    .data_i  (i_data),
    .count_o (data_pcnt)
  );

  // Next-state decode; every output is computed one cycle ahead so all ports are flops.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    log2_d    = log2_q;
    rep_d     = rep_q;
    wait_d    = wait_q;
    sum_d     = sum_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    res_sel_d = res_sel_q;
    res_sum_d = res_sum_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (i_abort && (state_q != StIdle)) begin
      // Abort wins over everything, including a handshake in the same cycle.
      state_d = StIdle;
      sel_d   = '0;
      rep_d   = '0;
      wait_d  = '0;
      sum_d   = '0;
      ctrl_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          // A simultaneous abort suppresses the start rather than launching a sweep.
          if (i_start && !i_abort) begin
            last_d = i_sel_last;
            log2_d = i_reps_log2;
            if (i_sel_first > i_sel_last) begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end else begin
              sel_d   = i_sel_first;
              rep_d   = '0;
              sum_d   = '0;
              ctrl_d  = ctrl_word(i_sel_first, 1'b0);
              state_d = StArm;
            end
          end
        end

        StArm: begin
          ctrl_d  = ctrl_word(sel_q, 1'b1);
          state_d = StFire;
        end

        StFire: begin
          ctrl_d  = ctrl_word(sel_q, 1'b0);
          wait_d  = '0;
          state_d = StWait;
        end

        StWait: begin
          if (wait_q == SettleLast) begin
            state_d = StSample;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        StSample: begin
          sum_d = sum_q + SUM_W'(data_pcnt);
          if (rep_q == rep_last(log2_q)) begin
            valid_d   = 1'b1;
            res_sel_d = sel_q;
            res_sum_d = sum_d;
            state_d   = StEmit;
          end else begin
            rep_d   = rep_q + REP_W'(1);
            state_d = StArm;
          end
        end

        StEmit: begin
          if (i_res_ready) begin
            valid_d = 1'b0;
            if (sel_q == last_q) begin
              ctrl_d  = '0;
              sel_d   = '0;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              // sel < last here, so the increment cannot wrap.
              sel_d   = sel_q + SEL_W'(1);
              rep_d   = '0;
              sum_d   = '0;
              ctrl_d  = ctrl_word(sel_q + SEL_W'(1), 1'b0);
              state_d = StArm;
            end
          end
        end

        default: begin
          ctrl_d  = '0;
          valid_d = 1'b0;
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  // Sequencer state, configuration and accumulator.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= '0;
      log2_q  <= '0;
      rep_q   <= '0;
      wait_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      log2_q  <= log2_d;
      rep_q   <= rep_d;
      wait_q  <= wait_d;
      sum_q   <= sum_d;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      res_sel_q <= '0;
      res_sum_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      res_sel_q <= res_sel_d;
      res_sum_q <= res_sum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_ctrl      = ctrl_q;
  assign o_res_valid = valid_q;
  assign o_res_sel   = res_sel_q;
  assign o_res_sum   = res_sum_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
